// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg: shared types, pattern table and LFSR helpers for the payload generator
package pkt_gen_pkg;
   typedef enum logic [1:0] {MODE_PAT, MODE_CNT, MODE_LFSR, MODE_RSVD} mode_t;
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   localparam logic [15:0] PATTERN [4] = '{16'hABCD, 16'h6969, 16'hFFFF, 16'h0420};
   // Right-shifting Galois form of x^32+x^22+x^2+x+1
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction
   function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction
   // Reserved mode falls back to the pattern; 32-bit beats see the pattern word in both halves
   function automatic logic [31:0] data_word(input mode_t m, input logic [1:0] k,
                                             input logic [31:0] cnt, input logic [31:0] lfsr);
      return (m == MODE_CNT) ? cnt : (m == MODE_LFSR) ? lfsr : {PATTERN[k], PATTERN[k]};
   endfunction
endpackage

// File: rtl/pkt_payload_gen_if.sv
// pkt_payload_gen_if: valid/ready/last beat stream from the payload generator
interface pkt_payload_gen_if #(parameter int DATA_SIZE = 16);
   logic                 axiov;
   logic [DATA_SIZE-1:0] axiod;
   logic                 axiol;
   logic                 axior;
   modport master (output axiov, axiod, axiol, input axior);
   modport slave  (input axiov, axiod, axiol, output axior);
endinterface

// File: rtl/lfsr32.sv
// lfsr32: 32-bit Galois LFSR with seed load and per-beat advance
module lfsr32
   import pkt_gen_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        adv,
   input  logic [31:0] seed,
   output logic [31:0] q
);
   always_ff @(posedge clk)
      if (rst) q <= 32'h1;
      else if (load) q <= lfsr_seed(seed);
      else if (adv) q <= lfsr_step(q);
endmodule

// File: rtl/pkt_payload_gen.sv
// pkt_payload_gen: start-triggered test-packet source (pattern/counter/LFSR) with repeats, gaps and backpressure
module pkt_payload_gen
   import pkt_gen_pkg::*;
#(
   parameter int DATA_SIZE = 16,
   parameter int MAX_BEATS = 64,
   parameter int LEN_W     = $clog2(MAX_BEATS + 1),
   parameter int GAP_W     = 8
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic [1:0]             mode_in,
   input  logic [LEN_W-1:0]       len_in,
   input  logic [7:0]             reps_in,
   input  logic [GAP_W-1:0]       gap_in,
   input  logic [31:0]            seed_in,
   pkt_payload_gen_if.master      tx,
   output logic                   busy,
   output logic [15:0]            pkt_count
);
   state_t               state;
   mode_t                mode_r;
   logic [LEN_W-1:0]     len_r, k;
   logic [7:0]           reps_r, sent;
   logic [GAP_W-1:0]     gap_r, gap_cnt;
   logic [31:0]          cnt, lq;
   logic                 stop_seen, axiov, axiol;
   logic [DATA_SIZE-1:0] axiod, w_start, w_adv, w_gap;
   logic [LEN_W-1:0]     k1, k_nx;
   logic                 len_ok, load, adv, last, lst_next, stop_any, run_done;

   assign len_ok   = (len_in != '0) && (len_in <= LEN_W'(MAX_BEATS));
   assign load     = (state == IDLE) && start && len_ok;
   assign adv      = (state == SEND) && tx.axior;
   assign k1       = k + 1'b1;
   assign last     = (k1 == len_r);
   assign lst_next = (LEN_W'(k1 + 1'b1) == len_r);
   assign k_nx     = last ? '0 : k1;
   assign stop_any = stop_seen || stop;
   assign run_done = ((reps_r != 8'd0) && (8'(sent + 8'd1) == reps_r)) || stop_any;
   // Beat data is registered, so the value for the beat after a transfer is formed from advanced sources
   assign w_start  = DATA_SIZE'(data_word(mode_t'(mode_in), 2'd0, seed_in, lfsr_seed(seed_in)));
   assign w_adv    = DATA_SIZE'(data_word(mode_r, k_nx[1:0], cnt + 32'd1, lfsr_step(lq)));
   assign w_gap    = DATA_SIZE'(data_word(mode_r, 2'd0, cnt, lq));

   lfsr32 u_lfsr (.clk(clk), .rst(rst), .load(load), .adv(adv), .seed(seed_in), .q(lq));

   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         mode_r    <= MODE_PAT;
         len_r     <= '0;
         reps_r    <= '0;
         gap_r     <= '0;
         k         <= '0;
         sent      <= '0;
         gap_cnt   <= '0;
         cnt       <= '0;
         stop_seen <= 1'b0;
         axiov     <= 1'b0;
         axiod     <= '0;
         axiol     <= 1'b0;
         busy      <= 1'b0;
         pkt_count <= '0;
      end else begin
         case (state)
            IDLE:
               if (load) begin
                  state     <= SEND;
                  mode_r    <= mode_t'(mode_in);
                  len_r     <= len_in;
                  reps_r    <= reps_in;
                  gap_r     <= gap_in;
                  cnt       <= seed_in;
                  k         <= '0;
                  sent      <= '0;
                  stop_seen <= 1'b0;
                  busy      <= 1'b1;
                  axiov     <= 1'b1;
                  axiod     <= w_start;
                  axiol     <= (len_in == LEN_W'(1));
               end
            SEND: begin
               if (stop) stop_seen <= 1'b1;
               if (tx.axior) begin
                  cnt <= cnt + 32'd1;
                  k   <= k_nx;
                  if (!last) begin
                     axiod <= w_adv;
                     axiol <= lst_next;
                  end else begin
                     sent      <= sent + 8'd1;
                     pkt_count <= pkt_count + 16'd1;
                     if (run_done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        axiov     <= 1'b0;
                        axiol     <= 1'b0;
                        stop_seen <= 1'b0;
                     end else if (gap_r != '0) begin
                        state   <= GAP;
                        gap_cnt <= gap_r;
                        axiov   <= 1'b0;
                        axiol   <= 1'b0;
                     end else begin
                        axiod <= w_adv;
                        axiol <= (len_r == LEN_W'(1));
                     end
                  end
               end
            end
            GAP: begin
               if (stop) stop_seen <= 1'b1;
               gap_cnt <= gap_cnt - 1'b1;
               if (gap_cnt == GAP_W'(1)) begin
                  if (stop_any) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     stop_seen <= 1'b0;
                  end else begin
                     state <= SEND;
                     axiov <= 1'b1;
                     axiod <= w_gap;
                     axiol <= (len_r == LEN_W'(1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end

   assign tx.axiov = axiov;
   assign tx.axiod = axiod;
   assign tx.axiol = axiol;
endmodule

// File: tb/tb_pkt_payload_gen.sv
// tb_pkt_payload_gen: directed checks of pattern, counter, LFSR, stop, backpressure and reset behaviour
module tb_pkt_payload_gen;
   logic        clk = 1'b0;
   logic        rst, start, stop;
   logic [1:0]  mode_in;
   logic [6:0]  len_in;
   logic [7:0]  reps_in, gap_in;
   logic [31:0] seed_in;
   logic        busy;
   logic [15:0] pkt_count;
   int          n_chk = 0, n_err = 0;

   pkt_payload_gen_if #(.DATA_SIZE(16)) tx ();

   pkt_payload_gen dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_in(mode_in), .len_in(len_in),
      .reps_in(reps_in), .gap_in(gap_in), .seed_in(seed_in), .tx(tx), .busy(busy), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [15:0] d, input logic l);
      chk({tag, " valid"}, 32'(tx.axiov), 32'd1);
      chk({tag, " data"}, 32'(tx.axiod), 32'(d));
      chk({tag, " last"}, 32'(tx.axiol), 32'(l));
      @(negedge clk);
   endtask

   task automatic quiet(input string tag, input logic b);
      chk({tag, " valid"}, 32'(tx.axiov), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'(b));
      @(negedge clk);
   endtask

   task automatic go(input logic [1:0] m, input logic [6:0] l, input logic [7:0] r,
                     input logic [7:0] g, input logic [31:0] s);
      mode_in = m; len_in = l; reps_in = r; gap_in = g; seed_in = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      logic [15:0] lfsr_exp [5] = '{16'h0001, 16'h0003, 16'h0002, 16'h0001, 16'h0003};
      logic [19:0] rdy_pat = 20'b1111_1011_0101_1001_0010;
      int got;
      rst = 1'b1; start = 1'b0; stop = 1'b0; tx.axior = 1'b1;
      mode_in = '0; len_in = '0; reps_in = '0; gap_in = '0; seed_in = '0;
      repeat (3) @(negedge clk);
      chk("rst valid", 32'(tx.axiov), 32'd0);
      chk("rst data", 32'(tx.axiod), 32'd0);
      chk("rst last", 32'(tx.axiol), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst pkt_count", 32'(pkt_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      // Pattern, len 7, one packet
      go(2'd0, 7'd7, 8'd1, 8'd0, 32'd0);
      beat("pat0", 16'hABCD, 1'b0);
      beat("pat1", 16'h6969, 1'b0);
      beat("pat2", 16'hFFFF, 1'b0);
      beat("pat3", 16'h0420, 1'b0);
      beat("pat4", 16'hABCD, 1'b0);
      beat("pat5", 16'h6969, 1'b0);
      beat("pat6", 16'hFFFF, 1'b1);
      chk("pat pkt_count", 32'(pkt_count), 32'd1);
      quiet("pat end", 1'b0);
      // Counter with wrap, two packets separated by a 3-cycle gap
      go(2'd1, 7'd4, 8'd2, 8'd3, 32'h0000_FFFE);
      beat("cnt0", 16'hFFFE, 1'b0);
      beat("cnt1", 16'hFFFF, 1'b0);
      beat("cnt2", 16'h0000, 1'b0);
      beat("cnt3", 16'h0001, 1'b1);
      chk("cnt mid pkt_count", 32'(pkt_count), 32'd2);
      quiet("gap0", 1'b1);
      quiet("gap1", 1'b1);
      quiet("gap2", 1'b1);
      beat("cnt4", 16'h0002, 1'b0);
      beat("cnt5", 16'h0003, 1'b0);
      beat("cnt6", 16'h0004, 1'b0);
      beat("cnt7", 16'h0005, 1'b1);
      chk("cnt pkt_count", 32'(pkt_count), 32'd3);
      quiet("cnt end", 1'b0);
      // LFSR from seed 0 under a fixed stall pattern
      go(2'd2, 7'd5, 8'd1, 8'd0, 32'd0);
      got = 0;
      for (int i = 0; i < 20 && got < 5; i++) begin
         tx.axior = rdy_pat[i];
         chk("lfsr valid", 32'(tx.axiov), 32'd1);
         chk("lfsr data", 32'(tx.axiod), 32'(lfsr_exp[got]));
         chk("lfsr last", 32'(tx.axiol), 32'(got == 4));
         if (tx.axior) got++;
         @(negedge clk);
      end
      tx.axior = 1'b1;
      chk("lfsr beats", 32'(got), 32'd5);
      chk("lfsr pkt_count", 32'(pkt_count), 32'd4);
      quiet("lfsr end", 1'b0);
      // Continuous run, back-to-back, stopped during packet 2
      go(2'd0, 7'd3, 8'd0, 8'd0, 32'd0);
      beat("run a0", 16'hABCD, 1'b0);
      beat("run a1", 16'h6969, 1'b0);
      beat("run a2", 16'hFFFF, 1'b1);
      stop = 1'b1;
      beat("run b0", 16'hABCD, 1'b0);
      stop = 1'b0;
      beat("run b1", 16'h6969, 1'b0);
      beat("run b2", 16'hFFFF, 1'b1);
      chk("run pkt_count", 32'(pkt_count), 32'd6);
      quiet("run end0", 1'b0);
      quiet("run end1", 1'b0);
      // Illegal lengths are ignored
      go(2'd0, 7'd0, 8'd1, 8'd0, 32'd0);
      quiet("len0", 1'b0);
      go(2'd0, 7'd65, 8'd1, 8'd0, 32'd0);
      quiet("len65", 1'b0);
      chk("illegal pkt_count", 32'(pkt_count), 32'd6);
      // Start while busy is ignored; a start on the cycle busy falls is taken
      go(2'd1, 7'd3, 8'd1, 8'd0, 32'h10);
      beat("busy0", 16'h0010, 1'b0);
      mode_in = 2'd0; len_in = 7'd5; start = 1'b1;
      beat("busy1", 16'h0011, 1'b0);
      start = 1'b0;
      beat("busy2", 16'h0012, 1'b1);
      chk("busy fall", 32'(busy), 32'd0);
      chk("busy pkt_count", 32'(pkt_count), 32'd7);
      go(2'd3, 7'd2, 8'd1, 8'd0, 32'd0);
      beat("rsvd0", 16'hABCD, 1'b0);
      beat("rsvd1", 16'h6969, 1'b1);
      chk("rsvd pkt_count", 32'(pkt_count), 32'd8);
      // Reset mid-packet, then a fresh packet
      go(2'd0, 7'd5, 8'd1, 8'd0, 32'd0);
      beat("pre0", 16'hABCD, 1'b0);
      beat("pre1", 16'h6969, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid rst valid", 32'(tx.axiov), 32'd0);
      chk("mid rst last", 32'(tx.axiol), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst pkt_count", 32'(pkt_count), 32'd0);
      @(negedge clk);
      quiet("post rst", 1'b0);
      go(2'd1, 7'd2, 8'd1, 8'd0, 32'h1234);
      beat("fresh0", 16'h1234, 1'b0);
      beat("fresh1", 16'h1235, 1'b1);
      chk("fresh pkt_count", 32'(pkt_count), 32'd1);
      quiet("fresh end", 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/pkt_payload_gen.md
# pkt_payload_gen

Parametrised test-payload source for the Ethernet TX path. On a start pulse it emits one or more packets of configurable length as a valid/ready beat stream, suitable for driving the `axiiv`/`axiid` inputs of `network_stack_tx`. Three data modes are supported: fixed pattern, incrementing counter, and LFSR. It adds repeat runs, inter-packet gaps, last-beat marking and backpressure, and replaces the hard-coded button-driven sequence in the board top level.

## Interface
- `DATA_SIZE`, 16, beat width; legal values 16 or 32.
- `MAX_BEATS`, 64, maximum beats per packet; `LEN_W = $clog2(MAX_BEATS+1)`.
- `GAP_W`, 8, width of the gap-length input.
- `clk`  in  1  system clock (`eth_refclk` in the top level).
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle run request.
- `stop`  in  1  finish the current packet, then idle.
- `mode_in`  in  2  data mode: 0 = pattern, 1 = counter, 2 = LFSR, 3 = reserved (treated as 0).
- `len_in`  in  LEN_W  beats per packet, 1..MAX_BEATS.
- `reps_in`  in  8  packets per run; 0 = continuous until `stop`.
- `gap_in`  in  GAP_W  idle cycles between packets.
- `seed_in`  in  32  counter start value or LFSR seed.
- `axior`  in  1  downstream ready; tie high for sinks without backpressure.
- `axiov`  out  1  beat valid.
- `axiod`  out  DATA_SIZE  beat data.
- `axiol`  out  1  last beat of packet; qualified by `axiov`.
- `busy`  out  1  high in every state except IDLE.
- `pkt_count`  out  16  packets completed since reset; wraps.

## Operation
- States: IDLE, SEND, GAP.
- IDLE: `start` with `1 <= len_in <= MAX_BEATS` latches `mode_in`, `len_in`, `reps_in`, `gap_in` and `seed_in`, then goes to SEND.
  - `start` with `len_in == 0` or `len_in > MAX_BEATS` is ignored.
  - `start` outside IDLE is ignored.
- SEND: a beat transfers when `axiov && axior`.
  - `axiod` and `axiol` hold while `axiov && !axior`.
  - `axiol` is asserted on beat index `len-1`.
- After the last beat transfers:
  - `pkt_count` increments.
  - If the run is done, go to IDLE. The run is done when the packets sent equal `reps` (with `reps != 0`), or when `stop` has been seen at any time during the run.
  - Otherwise, go to GAP if `gap > 0`, else go straight to SEND with the next packet's first beat on the following cycle.
- GAP: `axiov` stays low for exactly `gap` cycles, then SEND. `stop` seen during GAP goes to IDLE at the end of the gap.
- `stop` is sticky within a run; it clears on entry to IDLE.
- Data modes, with `k` = beat index within the packet:
  - Pattern: the 16-bit word at `PATTERN[k mod 4]` from the sequence ABCD, 6969, FFFF, 0420. For DATA_SIZE=32 the word is replicated in both halves.
  - Counter: a 32-bit counter loads `seed` at start and increments per transferred beat, continuing across packets in the run. `axiod` is its low DATA_SIZE bits; it wraps modulo 2^32.
  - LFSR: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advanced per transferred beat and continuing across packets. A seed of 0 is loaded as 1. `axiod` is its low DATA_SIZE bits.

## Timing
- All outputs are registered.
- Reset values: `axiov`=0, `axiod`=0, `axiol`=0, `busy`=0, `pkt_count`=0; state IDLE.
- `start` sampled at edge t: `busy` and `axiov` are high from t+1, carrying beat 0.
- With `axior` held high, a packet occupies exactly `len` consecutive cycles.
- Period between packet starts is `len + gap` cycles.
- `busy` falls the cycle after the final beat transfers; a new `start` is accepted on that cycle.
- `rst` mid-packet: outputs return to reset values on the next edge, with no `axiol` emitted.
- `pkt_count` updates on the cycle after the last-beat handshake.

## Structure
- `pkt_gen_pkg`: mode enum, state enum, `PATTERN` constant array, LFSR tap constant.
- Sub-module `lfsr32` provides load/advance controls and 32-bit state output. Pattern and counter logic stay inline.

## Test plan
- Pattern, DATA_SIZE=16, `len`=7, `reps`=1, `axior`=1 -> `axiod` is ABCD, 6969, FFFF, 0420, ABCD, 6969, FFFF on 7 consecutive cycles; `axiol` is high only on beat 7; `pkt_count`=1.
- Counter, `seed`=FFFE, `len`=4, `reps`=2, `gap`=3 -> beats FFFE, FFFF, 0000, 0001, then 3 idle cycles, then 0002..0005; `busy` falls after the 8th beat.
- Backpressure: random `axior` during a LFSR packet with `seed`=0 -> the accepted sequence equals the LFSR reference from state 1; data is stable while stalled; beat count equals `len`.
- `reps`=0, `gap`=0, `len`=3, `stop` pulsed mid-packet 2 -> packets are back-to-back with no idle cycle; packet 2 completes; no packet 3; `pkt_count`=2.
- Illegal and ignored starts:
  - `len_in`=0 -> no activity.
  - `start` while busy -> ignored.
  - `rst` during beat 2 -> `axiov`=0 and `busy`=0 next cycle; a fresh `start` produces a correct packet.
